uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one uart_tx serializer between NUM_REQ AXI-Stream byte sources.
- Grants are packet-locked: a winner keeps the serializer until its tlast byte has been transmitted.
- Issues one byte at a time as a single-cycle tvalid pulse into uart_tx, then waits for tx_done before issuing the next byte.
- A watchdog releases the lock when a transmission or a requester stalls.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-source arbiter and its surroundings: requester streams,
// the uart_tx handshake, and grant/watchdog status.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [8*NUM_REQ-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]   s_axis_tvalid;
    logic [NUM_REQ-1:0]   s_axis_tlast;
    logic [NUM_REQ-1:0]   s_axis_tready;
    logic [7:0]           tx_axis_tdata;
    logic                 tx_axis_tvalid;
    logic                 tx_busy;
    logic                 tx_done;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_valid;
    logic                 timeout_err;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_busy, tx_done,
        output s_axis_tready, tx_axis_tdata, tx_axis_tvalid, grant_id, grant_valid, timeout_err
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_busy, tx_done,
        input  s_axis_tready, tx_axis_tdata, tx_axis_tvalid, grant_id, grant_valid, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between NUM_REQ byte streams.
// Bytes go out one at a time; a watchdog drops the lock on a stalled packet or transmission.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam int              WD_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_grant_id;
    logic            r_grant_valid;
    logic [7:0]      r_data;
    logic            r_last;
    logic            r_timeout_err;
    logic [WD_W-1:0] r_wdog;

    logic            w_win;
    logic [ID_W-1:0] w_win_id;
    logic [ID_W:0]   w_sum;
    logic            w_hs;
    logic            w_done;
    logic            w_expire;
    logic            w_timeout;
    logic            w_release;
    logic            w_wd_run;
    logic [ID_W-1:0] w_ptr_nxt;

    // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_win    = 1'b0;
        w_win_id = '0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= NREQ) w_sum = w_sum - NREQ;
            if (bus.s_axis_tvalid[w_sum[ID_W-1:0]]) begin
                w_win    = 1'b1;
                w_win_id = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_hs      = (r_state == S_LOAD) && bus.s_axis_tvalid[r_grant_id] && !bus.tx_busy;
    assign w_done    = (r_state == S_WAIT) && bus.tx_done;
    assign w_expire  = (r_wdog == WD_MAX);
    // A handshake or tx_done on the expiry cycle takes precedence over the timeout.
    assign w_timeout = w_expire && (((r_state == S_LOAD) && !w_hs) ||
                                    ((r_state == S_WAIT) && !bus.tx_done));
    assign w_wd_run  = !w_expire && (((r_state == S_LOAD) && !w_hs) ||
                                     ((r_state == S_WAIT) && !bus.tx_done));
    assign w_release = w_timeout || (w_done && r_last);
    assign w_ptr_nxt = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_hs) w_state_nxt = S_ISSUE;
                     else if (w_timeout) w_state_nxt = S_IDLE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done) w_state_nxt = r_last ? S_IDLE : S_LOAD;
                     else if (w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = '0;
        if (r_state == S_LOAD)
            bus.s_axis_tready[r_grant_id] = bus.s_axis_tvalid[r_grant_id] & ~bus.tx_busy;
        bus.tx_axis_tvalid = (r_state == S_ISSUE);
        bus.tx_axis_tdata  = r_data;
        bus.grant_id       = r_grant_id;
        bus.grant_valid    = r_grant_valid;
        bus.timeout_err    = r_timeout_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_data        <= '0;
            r_last        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_timeout_err <= w_timeout;
            r_wdog        <= w_wd_run ? r_wdog + WD_W'(1) : '0;
            if ((r_state == S_IDLE) && w_win) begin
                r_grant_id    <= w_win_id;
                r_grant_valid <= 1'b1;
            end
            if (w_release) begin
                r_grant_valid <= 1'b0;
                r_rr_ptr      <= w_ptr_nxt;
            end
            if (w_hs) begin
                r_data <= bus.s_axis_tdata[{r_grant_id, 3'b000} +: 8];
                r_last <= bus.s_axis_tlast[r_grant_id];
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: main arbiter against a uart_tx stub, plus a short-watchdog instance
// whose tx_done is held low.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int FRAME = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_wd ();

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CLKS(2048)) dut (.clk(clk), .rst(rst), .bus(bus));
    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CLKS(100))  dut_wd (.clk(clk), .rst(rst), .bus(bus_wd));

    int checks = 0;
    int errors = 0;

    logic [8:0] srcq [NR][$];
    int         hs_cnt [NR];
    logic [7:0] q_tx [$];
    logic [1:0] q_gid [$];
    int         stub_cnt;
    int         to_cnt = 0;

    // uart_tx stub: busy for FRAME clocks after a start pulse, then a tx_done pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
            stub_cnt    <= 0;
        end else begin
            bus.tx_done <= 1'b0;
            if (bus.tx_axis_tvalid) begin
                bus.tx_busy <= 1'b1;
                stub_cnt    <= FRAME;
                q_tx.push_back(bus.tx_axis_tdata);
                q_gid.push_back(bus.grant_id);
            end else if (bus.tx_busy) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    bus.tx_busy <= 1'b0;
                    bus.tx_done <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) if (bus.timeout_err === 1'b1) to_cnt <= to_cnt + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                bus.s_axis_tvalid[i]       = 1'b1;
                bus.s_axis_tdata[8*i +: 8] = srcq[i][0][7:0];
                bus.s_axis_tlast[i]        = srcq[i][0][8];
            end else begin
                bus.s_axis_tvalid[i]       = 1'b0;
                bus.s_axis_tdata[8*i +: 8] = 8'h00;
                bus.s_axis_tlast[i]        = 1'b0;
            end
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs change just after the active edge.
    task automatic tick();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (hs[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                hs_cnt[i]++;
            end
        drive();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) srcq[i].delete();
        drive();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        srcq[0].push_back({1'b1, 8'hC0});
        srcq[2].push_back({1'b1, 8'hC2});
        drive();
        tick();
        tick();
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got %b exp 0", bus.grant_valid); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d exp 0", bus.grant_id); end
        checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rst_tready got %b exp 0000", bus.s_axis_tready); end
        checks++; if ({bus.tx_axis_tvalid, bus.tx_axis_tdata, bus.timeout_err} !== 10'd0) begin errors++; $display("FAIL rst_tx got v=%b d=%h to=%b exp 0", bus.tx_axis_tvalid, bus.tx_axis_tdata, bus.timeout_err); end
        apply_reset();
    endtask

    task automatic test_single();
        int base, hs0;
        apply_reset();
        base = q_tx.size();
        hs0  = hs_cnt[1];
        srcq[1].push_back({1'b1, 8'h5A});
        drive();
        tick();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got v=%b id=%0d exp v=1 id=1", bus.grant_valid, bus.grant_id); end
        checks++; if (bus.s_axis_tready !== 4'b0010) begin errors++; $display("FAIL single_tready got %b exp 0010", bus.s_axis_tready); end
        checks++; if (bus.tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_early_issue got %b exp 0", bus.tx_axis_tvalid); end
        tick();
        checks++; if (bus.tx_axis_tvalid !== 1'b1 || bus.tx_axis_tdata !== 8'h5A) begin errors++; $display("FAIL single_issue got v=%b d=%h exp v=1 d=5a", bus.tx_axis_tvalid, bus.tx_axis_tdata); end
        checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL single_tready_drop got %b exp 0000", bus.s_axis_tready); end
        tick();
        checks++; if (bus.tx_axis_tvalid !== 1'b0 || bus.tx_axis_tdata !== 8'h5A) begin errors++; $display("FAIL single_pulse_width got v=%b d=%h exp v=0 d=5a", bus.tx_axis_tvalid, bus.tx_axis_tdata); end
        for (int n = 0; n < 100 && bus.grant_valid; n++) tick();
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", bus.grant_valid); end
        checks++; if (dut.r_rr_ptr !== 2'd2) begin errors++; $display("FAIL single_rr_ptr got %0d exp 2", dut.r_rr_ptr); end
        checks++; if (q_tx.size() != base + 1 || hs_cnt[1] != hs0 + 1) begin errors++; $display("FAIL single_count got tx=%0d hs=%0d exp 1 1", q_tx.size() - base, hs_cnt[1] - hs0); end
        else begin
            checks++; if (q_tx[base] !== 8'h5A) begin errors++; $display("FAIL single_byte got %h exp 5a", q_tx[base]); end
        end
    endtask

    task automatic test_round_robin();
        int base;
        apply_reset();
        base = q_tx.size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) srcq[i].push_back({1'b1, 8'hA0 + 8'(i)});
        drive();
        for (int n = 0; n < 400 && q_tx.size() < base + 8; n++) tick();
        checks++;
        if (q_tx.size() < base + 8) begin errors++; $display("FAIL rr_count got %0d exp 8", q_tx.size() - base); end
        else
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (q_tx[base+k] !== 8'hA0 + 8'(k % NR) || q_gid[base+k] !== 2'(k % NR)) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got d=%h id=%0d exp d=%h id=%0d", k, q_tx[base+k], q_gid[base+k], 8'hA0 + 8'(k % NR), k % NR);
                end
            end
    endtask

    task automatic test_packet_lock();
        int base;
        logic [7:0] exp_d [4];
        logic [1:0] exp_g [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd0};
        apply_reset();
        base = q_tx.size();
        srcq[2].push_back({1'b0, 8'h11});
        srcq[2].push_back({1'b0, 8'h22});
        srcq[2].push_back({1'b1, 8'h33});
        drive();
        for (int n = 0; n < 10 && !bus.grant_valid; n++) tick();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin errors++; $display("FAIL lock_grant got v=%b id=%0d exp v=1 id=2", bus.grant_valid, bus.grant_id); end
        tick();
        srcq[0].push_back({1'b1, 8'h44});
        drive();
        for (int n = 0; n < 300 && q_tx.size() < base + 4; n++) tick();
        checks++;
        if (q_tx.size() < base + 4) begin errors++; $display("FAIL lock_count got %0d exp 4", q_tx.size() - base); end
        else
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_tx[base+k] !== exp_d[k] || q_gid[base+k] !== exp_g[k]) begin
                    errors++;
                    $display("FAIL lock_order[%0d] got d=%h id=%0d exp d=%h id=%0d", k, q_tx[base+k], q_gid[base+k], exp_d[k], exp_g[k]);
                end
            end
    endtask

    task automatic test_stall();
        int base, to0, hs0;
        logic [7:0] exp_d [3];
        exp_d = '{8'h01, 8'h02, 8'h33};
        apply_reset();
        base = q_tx.size();
        to0  = to_cnt;
        hs0  = hs_cnt[1];
        srcq[1].push_back({1'b0, 8'h01});
        srcq[3].push_back({1'b1, 8'h33});
        drive();
        for (int n = 0; n < 20 && hs_cnt[1] == hs0; n++) tick();
        checks++; if (hs_cnt[1] != hs0 + 1) begin errors++; $display("FAIL stall_first_hs got %0d exp 1", hs_cnt[1] - hs0); end
        for (int n = 0; n < 50; n++) tick();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL stall_lock got v=%b id=%0d exp v=1 id=1", bus.grant_valid, bus.grant_id); end
        srcq[1].push_back({1'b1, 8'h02});
        drive();
        for (int n = 0; n < 300 && q_tx.size() < base + 3; n++) tick();
        checks++;
        if (q_tx.size() < base + 3) begin errors++; $display("FAIL stall_count got %0d exp 3", q_tx.size() - base); end
        else
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (q_tx[base+k] !== exp_d[k]) begin errors++; $display("FAIL stall_order[%0d] got %h exp %h", k, q_tx[base+k], exp_d[k]); end
            end
        checks++; if (to_cnt != to0) begin errors++; $display("FAIL stall_timeout got %0d pulses exp 0", to_cnt - to0); end
    endtask

    task automatic test_watchdog();
        int early;
        apply_reset();
        bus_wd.s_axis_tvalid = 4'b0011;
        bus_wd.s_axis_tdata  = {8'h00, 8'h00, 8'h88, 8'h77};
        bus_wd.s_axis_tlast  = 4'b0010;
        tick();
        checks++; if (bus_wd.grant_valid !== 1'b1 || bus_wd.grant_id !== 2'd0) begin errors++; $display("FAIL wd_grant got v=%b id=%0d exp v=1 id=0", bus_wd.grant_valid, bus_wd.grant_id); end
        tick();
        checks++; if (bus_wd.tx_axis_tvalid !== 1'b1 || bus_wd.tx_axis_tdata !== 8'h77) begin errors++; $display("FAIL wd_issue got v=%b d=%h exp v=1 d=77", bus_wd.tx_axis_tvalid, bus_wd.tx_axis_tdata); end
        bus_wd.s_axis_tvalid[0] = 1'b0;
        tick();
        early = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k < 100) begin
                if (bus_wd.timeout_err !== 1'b0 || bus_wd.grant_valid !== 1'b1) early++;
            end else begin
                checks++; if (bus_wd.timeout_err !== 1'b1 || bus_wd.grant_valid !== 1'b0) begin errors++; $display("FAIL wd_expiry got to=%b gv=%b exp to=1 gv=0", bus_wd.timeout_err, bus_wd.grant_valid); end
            end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL wd_early got %0d bad cycles exp 0", early); end
        tick();
        checks++; if (bus_wd.timeout_err !== 1'b0 || bus_wd.grant_valid !== 1'b1 || bus_wd.grant_id !== 2'd1) begin errors++; $display("FAIL wd_regrant got to=%b v=%b id=%0d exp to=0 v=1 id=1", bus_wd.timeout_err, bus_wd.grant_valid, bus_wd.grant_id); end
        bus_wd.s_axis_tvalid = '0;
    endtask

    task automatic test_reset_mid();
        int base;
        apply_reset();
        srcq[2].push_back({1'b1, 8'h55});
        drive();
        for (int n = 0; n < 5; n++) tick();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2 || bus.tx_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got v=%b id=%0d busy=%b exp v=1 id=2 busy=1", bus.grant_valid, bus.grant_id, bus.tx_busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_grant got v=%b id=%0d to=%b exp 0", bus.grant_valid, bus.grant_id, bus.timeout_err); end
        checks++; if (bus.tx_axis_tvalid !== 1'b0 || bus.tx_axis_tdata !== 8'h00 || bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rmid_tx got v=%b d=%h rdy=%b exp 0", bus.tx_axis_tvalid, bus.tx_axis_tdata, bus.s_axis_tready); end
        base = q_tx.size();
        srcq[0].push_back({1'b1, 8'h66});
        srcq[2].push_back({1'b1, 8'h77});
        drive();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL rmid_regrant got v=%b id=%0d exp v=1 id=0", bus.grant_valid, bus.grant_id); end
        for (int n = 0; n < 200 && q_tx.size() < base + 2; n++) tick();
        checks++;
        if (q_tx.size() < base + 2) begin errors++; $display("FAIL rmid_count got %0d exp 2", q_tx.size() - base); end
        else if (q_tx[base] !== 8'h66 || q_tx[base+1] !== 8'h77) begin errors++; $display("FAIL rmid_order got %h %h exp 66 77", q_tx[base], q_tx[base+1]); end
    endtask

    initial begin
        bus.s_axis_tvalid    = '0;
        bus.s_axis_tdata     = '0;
        bus.s_axis_tlast     = '0;
        bus_wd.s_axis_tvalid = '0;
        bus_wd.s_axis_tdata  = '0;
        bus_wd.s_axis_tlast  = '0;
        bus_wd.tx_busy       = 1'b0;
        bus_wd.tx_done       = 1'b0;
        for (int i = 0; i < NR; i++) hs_cnt[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_stall();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
